trace_cache_sim: RTL and testbench

Parametrised N-way set-associative cache simulator core that supersedes the direct-mapped trace path.
- Accepts one memory-trace address at a time over a valid/ready handshake.
- Looks up a tag-only array (no data storage) with LRU replacement.
- Returns hit/miss with a modelled latency and keeps saturating hit/miss statistics.
- Sits between the trace source and the statistics/display logic.

---
 rtl/cache_sim_pkg.sv | 30 +++
 rtl/cache_lru_update.sv | 55 +++++
 rtl/trace_cache_sim.sv | 199 +++++++++++++++++++
 tb/tb_trace_cache_sim.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_sim_pkg.sv
// Shared types and helpers for the trace cache simulator core.
package cache_sim_pkg;

  // Width of the modelled latency field and of the wait down-counter.
  localparam int LAT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WAIT   = 2'd2
  } state_e;

  // Ceiling log2, usable in parameter elaboration.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cache_lru_update.sv
// Victim selection and age-vector update for one cache set.
// Ages form a permutation of 0..WAY-1, 0 = most recently used.
module cache_lru_update
  import cache_sim_pkg::*;
#(
  parameter int WAY   = 4,
  parameter int AGE_W = 2
) (
  input  logic [WAY-1:0][AGE_W-1:0] i_ages,
  input  logic [WAY-1:0]            i_valid,
  input  logic                      i_hit,
  input  logic [AGE_W-1:0]          i_hit_way,
  output logic [AGE_W-1:0]          o_victim,
  output logic                      o_victim_valid,
  output logic [WAY-1:0][AGE_W-1:0] o_ages
);

  logic             w_found;
  logic [AGE_W-1:0] w_sel;
  logic [AGE_W-1:0] w_age;

  // Victim: lowest-index invalid way, else the oldest way.
  always_comb begin
    w_found  = 1'b0;
    o_victim = '0;
    for (int j = 0; j < WAY; j++) begin
      if (!w_found && !i_valid[j]) begin
        o_victim = AGE_W'(j);
        w_found  = 1'b1;
      end
    end
    if (!w_found) begin
      for (int j = 0; j < WAY; j++) begin
        if (i_ages[j] == AGE_W'(WAY - 1)) o_victim = AGE_W'(j);
      end
    end
    // Evicting a valid line only happens when the set was full.
    o_victim_valid = !w_found;
  end

  // Promote the touched way to age 0 and age every younger way by one.
  always_comb begin
    w_sel = i_hit ? i_hit_way : o_victim;
    w_age = '0;
    for (int j = 0; j < WAY; j++) begin
      if (AGE_W'(j) == w_sel) w_age = i_ages[j];
    end
    o_ages = i_ages;
    for (int j = 0; j < WAY; j++) begin
      if (AGE_W'(j) == w_sel)    o_ages[j] = '0;
      else if (i_ages[j] < w_age) o_ages[j] = i_ages[j] + AGE_W'(1);
    end
  end

endmodule

// File: rtl/trace_cache_sim.sv
// N-way set-associative, tag-only cache simulator with LRU replacement.
// Accepts one trace address at a time, answers hit/miss after a modelled
// latency and keeps saturating hit/miss statistics.
// Optional: define EVICT_COUNT_EN to add a saturating evict_count output
// counting misses that displaced a valid line.
module trace_cache_sim
  import cache_sim_pkg::*;
#(
  parameter int WAY             = 4,
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int CACHE_SIZE_BYTE = 32768,
  parameter int ADDR_W          = 16,
  parameter int HIT_LAT         = 2,
  parameter int MISS_LAT        = 20,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trace_valid,
  output logic              trace_ready,
  input  logic [ADDR_W-1:0] trace_addr,
  input  logic              flush,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [LAT_W-1:0]  resp_latency,
  output logic [CNT_W-1:0]  hit_count,
`ifdef EVICT_COUNT_EN
  output logic [CNT_W-1:0]  evict_count,
`endif
  output logic [CNT_W-1:0]  miss_count
);

  localparam int SETS  = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY);
  localparam int OFF_W = clog2(BLOCK_SIZE_BYTE);
  localparam int IDX_W = clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int AGE_W = max2(1, clog2(WAY));
  localparam int LINE_W = ADDR_W - OFF_W;

  state_e r_state, w_next;

  logic [LINE_W-1:0] r_line;
  logic [LAT_W-1:0]  r_cnt;
  logic              r_hit;
  logic [AGE_W-1:0]  r_hit_way;
  logic [CNT_W-1:0]  r_hit_cnt, r_miss_cnt;

  logic [WAY-1:0]            r_vld [SETS];
  logic [WAY-1:0][TAG_W-1:0] r_tag [SETS];
  logic [WAY-1:0][AGE_W-1:0] r_age [SETS];

  logic [IDX_W-1:0]          w_idx;
  logic [TAG_W-1:0]          w_tag;
  logic [WAY-1:0]            w_set_vld;
  logic [WAY-1:0][TAG_W-1:0] w_set_tag;
  logic [WAY-1:0][AGE_W-1:0] w_set_age;
  logic                      w_hit;
  logic [AGE_W-1:0]          w_hit_way;
  logic [AGE_W-1:0]          w_victim;
  logic                      w_victim_valid;
  logic [WAY-1:0][AGE_W-1:0] w_new_age;
  logic                      w_accept;
  logic                      w_done;
  logic                      w_unused;

  // Byte offset never affects a tag-only lookup.
  assign w_unused = ^trace_addr[OFF_W-1:0];

  assign w_idx     = r_line[IDX_W-1:0];
  assign w_tag     = r_line[LINE_W-1:IDX_W];
  assign w_set_vld = r_vld[w_idx];
  assign w_set_tag = r_tag[w_idx];
  assign w_set_age = r_age[w_idx];
  assign w_accept  = trace_valid && trace_ready;
  assign w_done    = (r_state == WAIT) && (r_cnt == '0);

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

  // Parallel tag compare across the ways of the addressed set.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int j = 0; j < WAY; j++) begin
      if (w_set_vld[j] && (w_set_tag[j] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = AGE_W'(j);
      end
    end
  end

  cache_lru_update #(
    .WAY   (WAY),
    .AGE_W (AGE_W)
  ) u_lru (
    .i_ages         (w_set_age),
    .i_valid        (w_set_vld),
    .i_hit          (r_hit),
    .i_hit_way      (r_hit_way),
    .o_victim       (w_victim),
    .o_victim_valid (w_victim_valid),
    .o_ages         (w_new_age)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and handshake/response outputs; flush blocks acceptance.
  always_comb begin
    w_next       = r_state;
    trace_ready  = 1'b0;
    resp_valid   = 1'b0;
    resp_hit     = 1'b0;
    resp_latency = '0;
    case (r_state)
      IDLE: begin
        trace_ready = !flush;
        if (trace_valid && !flush) w_next = LOOKUP;
      end
      LOOKUP: w_next = WAIT;
      WAIT: begin
        if (r_cnt == '0) begin
          resp_valid   = 1'b1;
          resp_hit     = r_hit;
          resp_latency = r_hit ? LAT_W'(HIT_LAT) : LAT_W'(MISS_LAT);
          w_next       = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Capture the address, the lookup result and run the latency counter.
  // The counter is preloaded so the pulse lands exactly lat cycles after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line    <= '0;
      r_cnt     <= '0;
      r_hit     <= 1'b0;
      r_hit_way <= '0;
    end else begin
      if (w_accept) r_line <= trace_addr[ADDR_W-1:OFF_W];
      if (r_state == LOOKUP) begin
        r_hit     <= w_hit;
        r_hit_way <= w_hit_way;
        r_cnt     <= w_hit ? LAT_W'(HIT_LAT - 2) : LAT_W'(MISS_LAT - 2);
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - LAT_W'(1);
      end
    end
  end

  // Saturating hit/miss statistics, bumped on the response cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_done) begin
      if (r_hit && (r_hit_cnt != '1))   r_hit_cnt  <= r_hit_cnt + CNT_W'(1);
      if (!r_hit && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

`ifdef EVICT_COUNT_EN
  logic [CNT_W-1:0] r_evict_cnt;
  assign evict_count = r_evict_cnt;

  // Count misses that displaced a valid line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_evict_cnt <= '0;
    else if (w_done && !r_hit && w_victim_valid &&
             (r_evict_cnt != '1))               r_evict_cnt <= r_evict_cnt + CNT_W'(1);
  end
`endif

  // Valid bits and ages: flush clears valids only; completion applies LRU and fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_vld[s] <= '0;
        for (int w = 0; w < WAY; w++) r_age[s][w] <= AGE_W'(w);
      end
    end else if ((r_state == IDLE) && flush) begin
      for (int s = 0; s < SETS; s++) r_vld[s] <= '0;
    end else if (w_done) begin
      r_age[w_idx] <= w_new_age;
      if (!r_hit) r_vld[w_idx][w_victim] <= 1'b1;
    end
  end

  // Tag storage needs no reset: a tag is only meaningful under its valid bit.
  always_ff @(posedge clk) begin
    if (w_done && !r_hit) r_tag[w_idx][w_victim] <= w_tag;
  end

endmodule

// File: tb/tb_trace_cache_sim.sv
// Scoreboard bench for trace_cache_sim: default instance plus a CNT_W=4
// instance for counter saturation.
module tb_trace_cache_sim;

  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              trace_valid, trace_ready, flush;
  logic [ADDR_W-1:0] trace_addr;
  logic              resp_valid, resp_hit;
  logic [7:0]        resp_latency;
  logic [CNT_W-1:0]  hit_count, miss_count;

  logic              s_valid, s_ready, s_flush;
  logic [ADDR_W-1:0] s_addr;
  logic              s_resp_valid, s_resp_hit;
  logic [7:0]        s_resp_latency;
  logic [SAT_W-1:0]  s_hit_count, s_miss_count;

`ifdef EVICT_COUNT_EN
  logic [CNT_W-1:0]  evict_count;
  logic [SAT_W-1:0]  s_evict_count;
`endif

  trace_cache_sim u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_addr   (trace_addr),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_latency (resp_latency),
    .hit_count    (hit_count),
`ifdef EVICT_COUNT_EN
    .evict_count  (evict_count),
`endif
    .miss_count   (miss_count)
  );

  trace_cache_sim #(.CNT_W(SAT_W)) u_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .trace_valid  (s_valid),
    .trace_ready  (s_ready),
    .trace_addr   (s_addr),
    .flush        (s_flush),
    .resp_valid   (s_resp_valid),
    .resp_hit     (s_resp_hit),
    .resp_latency (s_resp_latency),
    .hit_count    (s_hit_count),
`ifdef EVICT_COUNT_EN
    .evict_count  (s_evict_count),
`endif
    .miss_count   (s_miss_count)
  );

  typedef struct {
    logic hit;
    int   lat;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_hits = 0;
  int   exp_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h @cyc %0d", tag, act, exp, cyc);
    end
  endtask

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_resp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_hit", {31'd0, resp_hit}, {31'd0, e.hit});
        chk("resp_latency", {24'd0, resp_latency}, e.lat);
        chk("resp_cycle", cyc, e.cyc + e.lat);
      end
    end
  end

  // One access on the default instance; optional flush in the presenting cycle.
  task automatic access(input logic [ADDR_W-1:0] a, input logic exp_hit, input bit pre_flush);
    int n;
    @(negedge clk);
    trace_addr  = a;
    trace_valid = 1'b1;
    if (pre_flush) begin
      flush = 1'b1;
      #1;
      chk("flush_blocks_ready", {31'd0, trace_ready}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
    end
    #1;
    n = 0;
    while (!trace_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!trace_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      trace_valid = 1'b0;
      return;
    end
    sb.push_back('{hit: exp_hit, lat: (exp_hit ? 2 : 20), cyc: cyc});
    if (exp_hit) exp_hits++;
    else         exp_miss++;
    @(negedge clk);
    trace_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    @(negedge clk);
    #1;
    chk("hit_count", {16'd0, hit_count}, exp_hits);
    chk("miss_count", {16'd0, miss_count}, exp_miss);
  endtask

  // 1 miss then 17 hits on one line of the 4-bit-counter instance.
  task automatic sat_run();
    int n;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      s_addr  = 16'h0100;
      s_valid = 1'b1;
      #1;
      n = 0;
      while (!s_ready && n < 40) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (!s_ready) begin
        chk("sat_ready_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
      s_valid = 1'b0;
      n = 0;
      while (!s_resp_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("sat_resp_seen", {31'd0, s_resp_valid}, 32'd1);
      chk("sat_resp_hit", {31'd0, s_resp_hit}, (i > 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("sat_hit_count", {28'd0, s_hit_count}, 32'd15);
    chk("sat_miss_count", {28'd0, s_miss_count}, 32'd1);
  endtask

  initial begin
    trace_valid = 1'b0;
    trace_addr  = '0;
    flush       = 1'b0;
    s_valid     = 1'b0;
    s_addr      = '0;
    s_flush     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'd0, trace_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_hit", {31'd0, resp_hit}, 32'd0);
    chk("rst_resp_latency", {24'd0, resp_latency}, 32'd0);
    chk("rst_hit_count", {16'd0, hit_count}, 32'd0);
    chk("rst_miss_count", {16'd0, miss_count}, 32'd0);

    // Basic miss then hit on the same line.
    access(16'h1230, 1'b0, 1'b0);
    access(16'h1234, 1'b1, 1'b0);

    // LRU on set 0: fill four ways, refresh 0x0000, then evict the oldest (0x2000).
    access(16'h0000, 1'b0, 1'b0);
    access(16'h2000, 1'b0, 1'b0);
    access(16'h4000, 1'b0, 1'b0);
    access(16'h6000, 1'b0, 1'b0);
    access(16'h0000, 1'b1, 1'b0);
    access(16'h8000, 1'b0, 1'b0);
`ifdef EVICT_COUNT_EN
    chk("evict_after_8000", {16'd0, evict_count}, 32'd1);
`endif
    access(16'h0000, 1'b1, 1'b0);
    access(16'h2000, 1'b0, 1'b0);
`ifdef EVICT_COUNT_EN
    chk("evict_after_2000", {16'd0, evict_count}, 32'd2);
`endif

    // Flush in IDLE drops the line but leaves the statistics alone.
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_hit_count", {16'd0, hit_count}, exp_hits);
    chk("flush_miss_count", {16'd0, miss_count}, exp_miss);
    access(16'h1230, 1'b0, 1'b0);

    // Flush and trace presented together: acceptance slips one cycle.
    access(16'h0040, 1'b0, 1'b1);

    // Reset 10 cycles into a miss abandons it.
    @(negedge clk);
    trace_addr  = 16'h0500;
    trace_valid = 1'b1;
    #1;
    chk("midrst_accept_ready", {31'd0, trace_ready}, 32'd1);
    @(negedge clk);
    trace_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    exp_hits = 0;
    exp_miss = 0;
    #1;
    chk("midrst_ready", {31'd0, trace_ready}, 32'd1);
    chk("midrst_hit_count", {16'd0, hit_count}, 32'd0);
    chk("midrst_miss_count", {16'd0, miss_count}, 32'd0);
    repeat (25) @(negedge clk);
    #1;
    chk("midrst_miss_count_late", {16'd0, miss_count}, 32'd0);
    access(16'h0500, 1'b0, 1'b0);

    sat_run();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
